// File: rtl/branch_controller_pkg.sv
// Shared definitions for the branch controller: NZCV bit positions,
// condition codes, FSM state encoding and default parameter values.
package branch_controller_pkg;

    // NZCV bit indices within the 4-bit flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Branch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } br_state_t;

    // Default parameter values
    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_OFF_W        = 11;
    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/branch_controller_condition_checker.sv
// Combinational condition-code evaluator over an NZCV flag vector.
module condition_checker
    import branch_controller_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition against the flags
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_controller.sv
// Branch sequencer: owns the NZCV register, accepts one branch at a time,
// resolves it via condition_checker, redirects fetch and holds flush.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_controller
    import branch_controller_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int OFF_W        = DEF_OFF_W,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flags_we,
    input  logic [3:0]        flags_in,
    output logic [3:0]        flags_q,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [OFF_W-1:0]  br_off,
    input  logic              br_link,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              lr_we,
    output logic [ADDR_W-1:0] lr_data,
    output logic              br_done,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0]  stat_taken,
    output logic [CNT_W-1:0]  stat_not_taken,
`endif
    output logic              br_taken
);

    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    if (FLUSH_CYCLES < 1) begin : g_bad_flush
        $error("FLUSH_CYCLES must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    br_state_t         state_q;
    logic [3:0]        cond_q;
    logic [3:0]        snap_q;
    logic [ADDR_W-1:0] pc_q;
    logic [OFF_W-1:0]  off_q;
    logic              link_q;
    logic [FCNT_W-1:0] cnt_q;

    logic              br_ready_q;
    logic              br_done_q;
    logic              redirect_valid_q;
    logic              flush_q;
    logic              lr_we_q;
    logic [ADDR_W-1:0] redirect_pc_q;
    logic [ADDR_W-1:0] lr_data_q;

    logic              cond_taken;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target;

    condition_checker u_cond (
        .cond  (cond_q),
        .flags (snap_q),
        .taken (cond_taken)
    );

    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign target   = pc_plus4 + (ADDR_W'($signed(off_q)) << 1);

    assign br_ready       = br_ready_q;
    assign br_done        = br_done_q;
    assign br_taken       = br_done_q & cond_taken;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign lr_we          = lr_we_q;
    assign lr_data        = lr_data_q;

    // Architectural flag register, written by the ALU in any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (flags_we) begin
            flags_q <= flags_in;
        end
    end

    // Branch FSM with registered handshake, redirect and flush outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cond_q           <= '0;
            snap_q           <= '0;
            pc_q             <= '0;
            off_q            <= '0;
            link_q           <= 1'b0;
            cnt_q            <= '0;
            br_ready_q       <= 1'b1;
            br_done_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            lr_we_q          <= 1'b0;
            redirect_pc_q    <= '0;
            lr_data_q        <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (br_valid) begin
                        cond_q     <= br_cond;
                        pc_q       <= br_pc;
                        off_q      <= br_off;
                        link_q     <= br_link;
                        // same-cycle ALU write is forwarded into the snapshot
                        snap_q     <= flags_we ? flags_in : flags_q;
                        br_ready_q <= 1'b0;
                        br_done_q  <= 1'b1;
                        state_q    <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    br_done_q <= 1'b0;
                    if (cond_taken) begin
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= target;
                        flush_q          <= 1'b1;
                        lr_we_q          <= link_q;
                        if (link_q) begin
                            lr_data_q <= pc_plus4 | ADDR_W'(1);
                        end
                        state_q <= ST_REDIRECT;
                    end else begin
                        br_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    redirect_valid_q <= 1'b0;
                    lr_we_q          <= 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_q   <= FCNT_W'(FLUSH_CYCLES - 1);
                        state_q <= ST_FLUSH;
                    end else begin
                        flush_q    <= 1'b0;
                        br_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == FCNT_W'(1)) begin
                        flush_q    <= 1'b0;
                        br_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - FCNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] stat_taken_q;
    logic [CNT_W-1:0] stat_not_taken_q;

    assign stat_taken     = stat_taken_q;
    assign stat_not_taken = stat_not_taken_q;

    // Saturating outcome counters, bumped on each resolution
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_taken_q     <= '0;
            stat_not_taken_q <= '0;
        end else if (br_done_q) begin
            if (cond_taken) begin
                if (stat_taken_q != '1) stat_taken_q <= stat_taken_q + CNT_W'(1);
            end else begin
                if (stat_not_taken_q != '1) stat_not_taken_q <= stat_not_taken_q + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_controller.sv
// Scoreboard bench for branch_controller: expected outcomes are queued at
// request time and compared when the DUT resolves / redirects.
module tb_branch_controller;

    localparam int ADDR_W = 32;
    localparam int OFF_W  = 11;
    localparam int FLUSH  = 2;
`ifdef BRANCH_STATS_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 16;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flags_we = 1'b0;
    logic [3:0]        flags_in = '0;
    logic [3:0]        flags_q;
    logic              br_valid = 1'b0;
    logic              br_ready;
    logic [3:0]        br_cond = '0;
    logic [ADDR_W-1:0] br_pc = '0;
    logic [OFF_W-1:0]  br_off = '0;
    logic              br_link = 1'b0;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;
    logic              lr_we;
    logic [ADDR_W-1:0] lr_data;
    logic              br_done;
    logic              br_taken;
`ifdef BRANCH_STATS_EN
    logic [TB_CNT_W-1:0] stat_taken;
    logic [TB_CNT_W-1:0] stat_not_taken;
`endif

    always #5 clk = ~clk;

    branch_controller #(
        .ADDR_W       (ADDR_W),
        .OFF_W        (OFF_W),
        .FLUSH_CYCLES (FLUSH),
        .CNT_W        (TB_CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flags_we       (flags_we),
        .flags_in       (flags_in),
        .flags_q        (flags_q),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_cond        (br_cond),
        .br_pc          (br_pc),
        .br_off         (br_off),
        .br_link        (br_link),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .lr_we          (lr_we),
        .lr_data        (lr_data),
        .br_done        (br_done),
`ifdef BRANCH_STATS_EN
        .stat_taken     (stat_taken),
        .stat_not_taken (stat_not_taken),
`endif
        .br_taken       (br_taken)
    );

    typedef struct {
        logic        tk;
        logic [31:0] tgt;
        logic        lk;
        logic [31:0] lr;
    } exp_t;

    exp_t exp_q[$];
    exp_t redir_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   flush_len = 0;
    logic [3:0] model_flags = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Resolution / redirect / flush-length monitor on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            flush_len = 0;
        end else begin
            if (br_taken && !br_done) check("taken_without_done", 1, 0);
            if ((br_done || flush) && br_ready) check("ready_while_busy", 1, 0);
            if (br_done) begin
                if (exp_q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("br_taken", br_taken, mon_e.tk);
                    if (mon_e.tk) redir_q.push_back(mon_e);
                end
            end
            if (redirect_valid) begin
                if (redir_q.size() == 0) check("redirect_unexpected", 1, 0);
                else begin
                    mon_e = redir_q.pop_front();
                    check("redirect_pc", redirect_pc, mon_e.tgt);
                    check("lr_we", lr_we, mon_e.lk);
                    if (mon_e.lk) check("lr_data", lr_data, mon_e.lr);
                    check("flush_at_redirect", flush, 1);
                end
            end else if (lr_we) begin
                check("lr_we_stray", 1, 0);
            end
            if (flush) flush_len++;
            else if (flush_len != 0) begin
                check("flush_len", flush_len, FLUSH);
                flush_len = 0;
            end
        end
    end

    task automatic write_flags(input logic [3:0] f);
        flags_we = 1'b1;
        flags_in = f;
        @(posedge clk);
        model_flags = f;
        #1;
        flags_we = 1'b0;
        check("flags_q", flags_q, model_flags);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (!(br_ready && !flush) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!(br_ready && !flush)) check("idle_timeout", 0, 1);
    endtask

    // Present one request; returns #1 after the accepting edge (cycle T+1)
    task automatic issue(input logic [3:0] c, input logic [31:0] pc, input logic [10:0] off,
                         input logic lk, input logic fwe, input logic [3:0] fin);
        int unsigned n = 0;
        logic [3:0]  snap;
        logic [31:0] offx;
        exp_t        e;
        while (!br_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!br_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        br_valid = 1'b1;
        br_cond  = c;
        br_pc    = pc;
        br_off   = off;
        br_link  = lk;
        flags_we = fwe;
        flags_in = fin;
        snap     = fwe ? fin : model_flags;
        offx     = {{21{off[10]}}, off};
        e.tk     = cond_ok(c, snap);
        e.tgt    = pc + 32'd4 + (offx << 1);
        e.lk     = lk;
        e.lr     = (pc + 32'd4) | 32'd1;
        exp_q.push_back(e);
        @(posedge clk);
        if (fwe) model_flags = fin;
        #1;
        br_valid = 1'b0;
        flags_we = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", br_ready, 1);
        check("rst_flags", flags_q, 0);
        check("rst_outs", {redirect_valid, flush, lr_we, br_done, br_taken}, 0);
        check("rst_rpc", redirect_pc, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // EQ taken with Z=1, target 0x10C
        write_flags(4'b0100);
        issue(4'b0000, 32'h100, 11'd4, 1'b0, 1'b0, 4'h0);
        check("eq_done_t1", br_done, 1);
        check("eq_ready_t1", br_ready, 0);
        wait_idle();

        // NE with Z=1: not taken, ready back at T+2
        issue(4'b0001, 32'h180, 11'd8, 1'b0, 1'b0, 4'h0);
        check("ne_ready_t1", br_ready, 0);
        @(posedge clk); #1;
        check("ne_ready_t2", br_ready, 1);
        check("ne_no_redirect", redirect_valid, 0);

        // Forwarded Z=1 at accept, then Z cleared during EVAL
        write_flags(4'b0000);
        issue(4'b0000, 32'h300, 11'd16, 1'b0, 1'b1, 4'b0100);
        flags_we = 1'b1;
        flags_in = 4'b0000;
        @(posedge clk);
        model_flags = 4'b0000;
        #1;
        flags_we = 1'b0;
        wait_idle();

        // BL, offset -2: target == pc, link 0x205
        issue(4'b1110, 32'h200, 11'h7FE, 1'b1, 1'b0, 4'h0);
        wait_idle();

        // Target wrap, then reset during FLUSH
        write_flags(4'b1111);
        issue(4'b1110, 32'hFFFF_FFFC, 11'd0, 1'b0, 1'b0, 4'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("in_flush", flush, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_flush", flush, 0);
        check("rst_mid_flags", flags_q, 0);
        check("rst_mid_ready", br_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_flags = 4'b0000;
        check("post_rst_idle", {br_done, redirect_valid, flush}, 0);

        // Randomized traffic through the scoreboard
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) write_flags(4'($urandom_range(0, 15)));
            issue(4'($urandom_range(0, 15)), $urandom, 11'($urandom_range(0, 2047)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        wait_idle();

`ifdef BRANCH_STATS_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_flags = 4'b0000;
        check("stat_rst", {stat_taken, stat_not_taken}, 0);
        for (int i = 0; i < 5; i++) issue(4'b1110, 32'h400 + 32'(i * 16), 11'd2, 1'b0, 1'b0, 4'h0);
        wait_idle();
        check("stat_taken_sat", stat_taken, 3);
        check("stat_not_taken", stat_not_taken, 0);
`endif

        repeat (6) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("redir_q_drained", redir_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
